// File: rtl/perceptron_trainer.sv
// Online trainer for the two-input perceptron: classic perceptron rule,
// learning rate 1, repeated epochs until an error-free pass or the epoch cap.
module perceptron_trainer #(
   parameter int N_SAMPLES  = 4,
   parameter int MAX_EPOCHS = 15,
   parameter int W1_INIT    = -2,
   parameter int W2_INIT    = -2,
   parameter int B_INIT     = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic signed [3:0] s_x1,
   input  logic signed [3:0] s_x2,
   input  logic              s_target,
   output logic signed [3:0] w1,
   output logic signed [3:0] w2,
   output logic signed [7:0] bias,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [3:0]        epoch,
   output logic [7:0]        err_cnt
);

   localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

   typedef enum logic [2:0] {
      IDLE, WAIT, EVAL, UPDATE, EPOCH_END, DONE
   } state_t;

   state_t state;

   logic [IW-1:0]     idx;
   logic signed [3:0] x1_q;
   logic signed [3:0] x2_q;
   logic              tgt_q;
   logic              pred;

   logic signed [7:0] p1;
   logic signed [7:0] p2;
   logic signed [9:0] sum;

   logic signed [4:0] w1_add;
   logic signed [4:0] w1_sub;
   logic signed [4:0] w2_add;
   logic signed [4:0] w2_sub;
   logic signed [8:0] b_add;
   logic signed [8:0] b_sub;

   function automatic logic signed [3:0] sat4(input logic signed [4:0] v);
      if (v > 5'sd7)
         return 4'sd7;
      else if (v < 5'sb11000)
         return 4'sb1000;
      else
         return v[3:0];
   endfunction

   function automatic logic signed [7:0] sat8(input logic signed [8:0] v);
      if (v > 9'sd127)
         return 8'sd127;
      else if (v < 9'sb110000000)
         return 8'sb10000000;
      else
         return v[7:0];
   endfunction

   assign p1  = w1 * x1_q;
   assign p2  = w2 * x2_q;
   assign sum = {{2{p1[7]}}, p1} + {{2{p2[7]}}, p2}
              + {{2{bias[7]}}, bias};

   // one extra bit of headroom so saturation sees the true result
   assign w1_add = {w1[3], w1} + {x1_q[3], x1_q};
   assign w1_sub = {w1[3], w1} - {x1_q[3], x1_q};
   assign w2_add = {w2[3], w2} + {x2_q[3], x2_q};
   assign w2_sub = {w2[3], w2} - {x2_q[3], x2_q};
   assign b_add  = {bias[7], bias} + 9'sd1;
   assign b_sub  = {bias[7], bias} - 9'sd1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         w1        <= 4'(W1_INIT);
         w2        <= 4'(W2_INIT);
         bias      <= 8'(B_INIT);
         epoch     <= '0;
         err_cnt   <= '0;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         converged <= 1'b0;
         s_ready   <= 1'b0;
         x1_q      <= '0;
         x2_q      <= '0;
         tgt_q     <= 1'b0;
         pred      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  w1        <= 4'(W1_INIT);
                  w2        <= 4'(W2_INIT);
                  bias      <= 8'(B_INIT);
                  epoch     <= '0;
                  err_cnt   <= '0;
                  idx       <= '0;
                  done      <= 1'b0;
                  converged <= 1'b0;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // s_ready rises one cycle after entering WAIT
               if (s_valid && s_ready) begin
                  x1_q    <= s_x1;
                  x2_q    <= s_x2;
                  tgt_q   <= s_target;
                  s_ready <= 1'b0;
                  state   <= EVAL;
               end else begin
                  s_ready <= 1'b1;
               end
            end
            EVAL: begin
               pred  <= (sum > 10'sd0);
               state <= UPDATE;
            end
            UPDATE: begin
               if (tgt_q && !pred) begin
                  w1      <= sat4(w1_add);
                  w2      <= sat4(w2_add);
                  bias    <= sat8(b_add);
                  err_cnt <= err_cnt + 8'd1;
               end else if (!tgt_q && pred) begin
                  w1      <= sat4(w1_sub);
                  w2      <= sat4(w2_sub);
                  bias    <= sat8(b_sub);
                  err_cnt <= err_cnt + 8'd1;
               end
               if (idx == IW'(N_SAMPLES - 1)) begin
                  state <= EPOCH_END;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= WAIT;
               end
            end
            EPOCH_END: begin
               if (err_cnt == 8'd0) begin
                  converged <= 1'b1;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (epoch == 4'(MAX_EPOCHS - 1)) begin
                  converged <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  epoch   <= epoch + 4'd1;
                  err_cnt <= '0;
                  idx     <= '0;
                  state   <= WAIT;
               end
            end
            DONE: begin
               // continue-training keeps the learned weights
               if (start) begin
                  epoch     <= '0;
                  err_cnt   <= '0;
                  idx       <= '0;
                  done      <= 1'b0;
                  converged <= 1'b0;
                  busy      <= 1'b1;
                  state     <= WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
